// File: rtl/lsu_byte_seq_if.sv
// Bundle of scheduler, memory-bus and register-file signals around the
// byte-sequencing load/store unit. The LSU connects through the slave modport
// (it serves scheduler requests); the environment side uses master.
interface lsu_byte_seq_if;
    logic        sched_req;
    logic        sched_store;
    logic        sched_word;
    logic [15:0] lsu_adr;
    logic [15:0] lsu_payload;
    logic        lsu_busy;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    logic [15:0] rf_ld_data;
    logic        rf_ld_valid;
    logic        lsu_done;
    logic        lsu_fault;

    modport slave (
        input  sched_req, sched_store, sched_word, lsu_adr, lsu_payload,
        input  mem_din, mem_ready,
        output lsu_busy, mem_adr, mem_dout, mem_rd, mem_wr,
        output rf_ld_data, rf_ld_valid, lsu_done, lsu_fault
    );

    modport master (
        output sched_req, sched_store, sched_word, lsu_adr, lsu_payload,
        output mem_din, mem_ready,
        input  lsu_busy, mem_adr, mem_dout, mem_rd, mem_wr,
        input  rf_ld_data, rf_ld_valid, lsu_done, lsu_fault
    );
endinterface

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: splits 8/16-bit accesses into little-endian byte
// transfers on an 8-bit bus, bounds every bus wait with a timeout, and
// returns load data to the register file. All outputs are registered.
module lsu_byte_seq #(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    lsu_byte_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    state_t              state_q, state_d;
    logic [15:0]         adr_q, adr_d;
    logic [15:0]         payload_q, payload_d;
    logic                store_q, store_d;
    logic                word_q, word_d;
    logic [15:0]         data_q, data_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                busy_q, busy_d;
    logic [15:0]         mem_adr_q, mem_adr_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [15:0]         rf_ld_data_q, rf_ld_data_d;
    logic                rf_ld_valid_q, rf_ld_valid_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                timeout;

    // The limit cycle still honours a late acknowledge; only a missing one aborts.
    assign timeout = (wait_q == WAIT_MAX) && !bus.mem_ready;

    // Next-state and next-output computation for the byte sequencer.
    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        payload_d     = payload_q;
        store_d       = store_q;
        word_d        = word_q;
        data_d        = data_q;
        wait_d        = wait_q;
        busy_d        = busy_q;
        mem_adr_d     = mem_adr_q;
        mem_dout_d    = mem_dout_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        rf_ld_data_d  = rf_ld_data_q;
        rf_ld_valid_d = 1'b0;
        done_d        = 1'b0;
        fault_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.sched_req) begin
                    state_d    = S_LO;
                    adr_d      = bus.lsu_adr;
                    payload_d  = bus.lsu_payload;
                    store_d    = bus.sched_store;
                    word_d     = bus.sched_word;
                    wait_d     = '0;
                    busy_d     = 1'b1;
                    mem_adr_d  = bus.lsu_adr;
                    mem_dout_d = bus.lsu_payload[7:0];
                    mem_wr_d   = bus.sched_store;
                    mem_rd_d   = !bus.sched_store;
                end
            end
            S_LO: begin
                if (bus.mem_ready) begin
                    if (!store_q) begin
                        data_d = {8'h00, bus.mem_din};
                    end
                    if (word_q) begin
                        state_d    = S_HI;
                        wait_d     = '0;
                        mem_adr_d  = adr_q + 16'd1;
                        mem_dout_d = payload_q[15:8];
                    end else begin
                        state_d  = S_DONE;
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        done_d   = 1'b1;
                        if (!store_q) begin
                            rf_ld_valid_d = 1'b1;
                            rf_ld_data_d  = data_d;
                        end
                    end
                end else if (timeout) begin
                    state_d  = S_IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    fault_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_HI: begin
                if (bus.mem_ready) begin
                    if (!store_q) begin
                        data_d = {bus.mem_din, data_q[7:0]};
                    end
                    state_d  = S_DONE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    done_d   = 1'b1;
                    if (!store_q) begin
                        rf_ld_valid_d = 1'b1;
                        rf_ld_data_d  = data_d;
                    end
                end else if (timeout) begin
                    // A low byte already written by a word store stays written.
                    state_d  = S_IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    fault_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight transfer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            adr_q         <= '0;
            payload_q     <= '0;
            store_q       <= 1'b0;
            word_q        <= 1'b0;
            data_q        <= '0;
            wait_q        <= '0;
            busy_q        <= 1'b0;
            mem_adr_q     <= '0;
            mem_dout_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            rf_ld_data_q  <= '0;
            rf_ld_valid_q <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            payload_q     <= payload_d;
            store_q       <= store_d;
            word_q        <= word_d;
            data_q        <= data_d;
            wait_q        <= wait_d;
            busy_q        <= busy_d;
            mem_adr_q     <= mem_adr_d;
            mem_dout_q    <= mem_dout_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            rf_ld_data_q  <= rf_ld_data_d;
            rf_ld_valid_q <= rf_ld_valid_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.lsu_busy    = busy_q;
    assign bus.mem_adr     = mem_adr_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.rf_ld_data  = rf_ld_data_q;
    assign bus.rf_ld_valid = rf_ld_valid_q;
    assign bus.lsu_done    = done_q;
    assign bus.lsu_fault   = fault_q;
endmodule
